// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 host transmitter states and keyboard command codes
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchroniser, clock deglitch filter and falling-edge detect
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_in,
  input  logic reset,
  input  logic ps2_clock,
  input  logic ps2_data,
  output logic clock_filt,
  output logic data_sync,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clock_sync;
  logic [1:0]    data_sync_r;
  logic [CW-1:0] stable_cnt;
  logic          clock_prev;

  // Sync stages reset to the idle-high bus level so reset never fakes a fall.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      clock_sync  <= 2'b11;
      data_sync_r <= 2'b11;
      stable_cnt  <= '0;
      clock_filt  <= 1'b1;
      clock_prev  <= 1'b1;
    end else begin
      clock_sync  <= {clock_sync[0], ps2_clock};
      data_sync_r <= {data_sync_r[0], ps2_data};
      clock_prev  <= clock_filt;
      if (clock_sync[1] == clock_filt) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
        clock_filt <= clock_sync[1];
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign data_sync = data_sync_r[1];
  assign fall      = clock_prev & ~clock_filt;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with open-drain line control
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic       error,
  output logic       err_timeout
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic          clock_filt;
  logic          data_sync;
  logic          fall;
  ps2_tx_state_t state;
  logic [7:0]    shreg;
  logic          parity;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    bit_idx;
  logic          busy;
  logic          timeout;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk_in     (clk_in),
    .reset      (reset),
    .ps2_clock  (ps2_clock),
    .ps2_data   (ps2_data),
    .clock_filt (clock_filt),
    .data_sync  (data_sync),
    .fall       (fall)
  );

  assign busy    = (state != IDLE) && (state != INHIBIT);
  // Counter starts at 0 in START; firing as it would step to TIMEOUT_CYCLES-1.
  assign timeout = (to_cnt == TW'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= IDLE;
      tx_ready     <= 1'b1;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      rx_inhibit   <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_timeout  <= 1'b0;
      shreg        <= '0;
      parity       <= 1'b0;
      inh_cnt      <= '0;
      to_cnt       <= '0;
      bit_idx      <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (busy) to_cnt <= to_cnt + 1'b1;

      if (busy && timeout) begin
        state        <= IDLE;
        ps2_clock_oe <= 1'b0;
        ps2_data_oe  <= 1'b0;
        rx_inhibit   <= 1'b0;
        error        <= 1'b1;
        err_timeout  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            tx_ready     <= 1'b1;
            rx_inhibit   <= 1'b0;
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            inh_cnt      <= '0;
            to_cnt       <= '0;
            bit_idx      <= '0;
            if (tx_valid && tx_ready) begin
              shreg        <= tx_data;
              parity       <= odd_parity(tx_data);
              state        <= INHIBIT;
              tx_ready     <= 1'b0;
              rx_inhibit   <= 1'b1;
              ps2_clock_oe <= 1'b1;
              ps2_data_oe  <= (INHIBIT_CYCLES == 1);
            end
          end
          INHIBIT: begin
            inh_cnt <= inh_cnt + 1'b1;
            if (inh_cnt == IW'(INHIBIT_CYCLES - 2)) ps2_data_oe <= 1'b1;
            if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
              state        <= START;
              ps2_clock_oe <= 1'b0;
              ps2_data_oe  <= 1'b1;
              to_cnt       <= '0;
            end
          end
          START: if (fall) begin
            ps2_data_oe <= ~shreg[0];
            bit_idx     <= 4'd1;
            state       <= DATA;
          end
          DATA: if (fall) begin
            if (bit_idx == 4'd8) begin
              ps2_data_oe <= ~parity;
              state       <= PARITY;
            end else begin
              ps2_data_oe <= ~shreg[bit_idx[2:0]];
              bit_idx     <= bit_idx + 1'b1;
            end
          end
          PARITY: if (fall) begin
            ps2_data_oe <= 1'b0;
            state       <= STOP;
          end
          // Stop bit is on the wire; the device samples it on this rising edge, then drives the ack.
          STOP: if (clock_filt) state <= ACK;
          ACK: if (fall) begin
            if (!data_sync) begin
              state <= WAIT_IDLE;
            end else begin
              error       <= 1'b1;
              err_timeout <= 1'b0;
              rx_inhibit  <= 1'b0;
              state       <= IDLE;
            end
          end
          WAIT_IDLE: if (clock_filt && data_sync) begin
            done       <= 1'b1;
            rx_inhibit <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int N = 40;
  localparam int T = 3000;
  localparam int F = 8;
  localparam int H = 40;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clock;
  logic       ps2_data;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;
  logic       rx_inhibit;
  logic       done;
  logic       error;
  logic       err_timeout;

  assign ps2_clock = ~ps2_clock_oe & dev_clk;
  assign ps2_data  = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(N), .TIMEOUT_CYCLES(T), .FILTER_LEN(F)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .ps2_clock    (ps2_clock),
    .ps2_data     (ps2_data),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe),
    .rx_inhibit   (rx_inhibit),
    .done         (done),
    .error        (error),
    .err_timeout  (err_timeout)
  );

  always #10 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wire order: bit0 start, bits1-8 data LSB first, bit9 odd parity, bit10 stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  // Outcome model: 0 = done, 1 = NACK, 2 = timeout.
  bit mon_en = 0;
  bit win = 0;
  bit after = 0;
  int win_start = 0;
  int win_end = 0;
  int exp_kind = 0;
  int n_done = 0;
  int n_err = 0;

  always @(negedge clk_in) begin
    if (mon_en) begin
      bit in_win;
      if (after) begin
        chk("next_ready", tx_ready, 1);
        chk("next_clock_oe", ps2_clock_oe, 0);
        chk("next_data_oe", ps2_data_oe, 0);
        chk("next_rx_inhibit", rx_inhibit, 0);
        chk("next_done", done, 0);
        chk("next_error", error, 0);
        after = 0;
      end
      in_win = win && (cyc >= win_start) && (cyc <= win_end);
      chk("clock_oe_window", ps2_clock_oe, in_win);
      if (in_win) begin
        chk("inhibit_data_oe", ps2_data_oe, cyc == win_end);
        chk("inhibit_rx_inhibit", rx_inhibit, 1);
        chk("inhibit_ready", tx_ready, 0);
      end
      if (tx_ready) chk("ready_vs_inhibit", rx_inhibit, 0);
      if (done || error) begin
        chk("done_and_error", done & error, 0);
        chk("end_ready_low", tx_ready, 0);
        chk("end_outcome", error ? (err_timeout ? 2 : 1) : 0, exp_kind);
        if (error && err_timeout) chk("timeout_cycle", cyc - win_end, T);
        if (done) n_done++;
        else n_err++;
        after = 1;
      end
      if (tx_valid && tx_ready && !reset) begin
        win       = 1;
        win_start = cyc + 1;
        win_end   = cyc + N;
      end
      if (reset) begin
        win   = 0;
        after = 1;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int w = 0;
    @(negedge clk_in);
    while (!tx_ready && w < 1000) begin
      @(negedge clk_in);
      w++;
    end
    if (!tx_ready) chk("send_wait_ready", 0, 1);
    @(posedge clk_in);
    #1 tx_data = b;
    tx_valid = 1'b1;
    @(posedge clk_in);
    #1 tx_valid = 1'b0;
  endtask

  task automatic dev_frame(input bit ack, input bit glitch, input int abort_at,
                           output logic [10:0] got, output bit ok);
    int w;
    ok  = 1;
    got = '0;
    w = 0;
    while (!ps2_clock_oe && w < 2000) begin
      @(negedge clk_in);
      w++;
    end
    w = 0;
    while (ps2_clock_oe && w < 2000) begin
      @(negedge clk_in);
      w++;
    end
    if (ps2_clock_oe || w == 0) begin
      ok = 0;
      return;
    end
    got[0] = ps2_data;
    repeat (H) @(negedge clk_in);
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk_in);
      got[i]  = ps2_data;
      dev_clk = 1'b1;
      if (i == abort_at) return;
      repeat (H / 2) @(negedge clk_in);
      if (i == 10 && ack) dev_data = 1'b0;
      if (glitch && i == 5) begin
        dev_clk = 1'b0;
        repeat (F - 3) @(negedge clk_in);
        dev_clk = 1'b1;
      end
      repeat (H / 2) @(negedge clk_in);
    end
    dev_clk = 1'b0;
    repeat (H) @(negedge clk_in);
    dev_clk = 1'b1;
    repeat (H / 2) @(negedge clk_in);
    dev_data = 1'b1;
    repeat (H) @(negedge clk_in);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, input bit glitch,
                           input bit inject, output logic [10:0] got);
    int nd0 = n_done;
    int ne0 = n_err;
    int oe_hi = 0;
    bit ok;
    exp_kind = ack ? 0 : 1;
    send(b);
    fork
      dev_frame(ack, glitch, 0, got, ok);
      if (inject) begin
        repeat (N + 300) @(posedge clk_in);
        #1 tx_data = 8'hFF;
        tx_valid = 1'b1;
        @(posedge clk_in);
        #1 tx_valid = 1'b0;
      end
    join
    repeat (20) @(negedge clk_in);
    chk("device_ok", ok, 1);
    chk("frame_bits", got, frame_of(b));
    chk("done_count", n_done, nd0 + (ack ? 1 : 0));
    chk("error_count", n_err, ne0 + (ack ? 0 : 1));
    if (inject) begin
      repeat (N + 100) begin
        @(negedge clk_in);
        if (ps2_clock_oe) oe_hi++;
      end
      chk("no_second_frame", oe_hi, 0);
      chk("no_second_done", n_done, nd0 + 1);
    end
  endtask

  initial begin
    logic [10:0] got;
    bit ok;
    int nd0;
    int ne0;
    repeat (3) @(posedge clk_in);
    #1 reset = 1'b0;
    @(negedge clk_in);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_clock_oe", ps2_clock_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_rx_inhibit", rx_inhibit, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_timeout", err_timeout, 0);
    mon_en = 1;

    run_frame(8'hED, 1, 0, 0, got);
    chk("lit_ED", got, 11'h7DA);
    run_frame(8'h07, 1, 0, 0, got);
    chk("lit_07", got, 11'h40E);
    chk("lit_07_parity", got[9], 0);
    run_frame(8'h00, 1, 1, 0, got);
    chk("lit_00_glitch", got, 11'h600);
    run_frame(8'h55, 0, 0, 0, got);
    run_frame(8'hF0, 1, 0, 1, got);

    nd0 = n_done;
    ne0 = n_err;
    exp_kind = 2;
    send(8'hFF);
    repeat (N + T + 50) @(negedge clk_in);
    chk("timeout_error_count", n_err, ne0 + 1);
    chk("timeout_done_count", n_done, nd0);

    nd0 = n_done;
    ne0 = n_err;
    exp_kind = 0;
    send(8'hAA);
    dev_frame(1, 0, 4, got, ok);
    chk("abort_device_ok", ok, 1);
    @(posedge clk_in);
    #1 reset = 1'b1;
    @(posedge clk_in);
    #1 reset = 1'b0;
    repeat (30) @(negedge clk_in);
    chk("reset_no_done", n_done, nd0);
    chk("reset_no_error", n_err, ne0);
    run_frame(8'hF4, 1, 0, 0, got);
    chk("lit_F4", got, 11'h5E8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(20 * 60000);
    failures++;
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
